// File: rtl/hazard_pkg.sv
// Shared encodings and types for the pipeline hazard controller.
package hazard_pkg;

   localparam int unsigned REG_W  = 5;
   localparam int unsigned SEL_W  = 2;
   localparam int unsigned WDOG_W = 16;
   localparam int unsigned PERF_W = 32;

   // Writeback source encodings of the execute-stage instruction.
   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_LOAD = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;
   localparam logic [1:0] WB_IMMU = 2'b11;

   // Execute operand mux selects; 2'b11 is never produced.
   localparam logic [SEL_W-1:0] FWD_RF  = 2'b00;
   localparam logic [SEL_W-1:0] FWD_WB  = 2'b01;
   localparam logic [SEL_W-1:0] FWD_MEM = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_MEM_WAIT = 2'b01,
      ST_FAULT    = 2'b10
   } state_e;

   // Stall/flush strobes driven to the stage registers.
   typedef struct packed {
      logic stall_f;
      logic stall_d;
      logic stall_e;
      logic stall_m;
      logic flush_d;
      logic flush_e;
   } strobe_t;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding comparator: memory stage wins over writeback.
module fwd_sel
   import hazard_pkg::*;
(
   input  logic [REG_W-1:0] rs,
   input  logic [REG_W-1:0] rd_m,
   input  logic             rd_write_m,
   input  logic [REG_W-1:0] rd_w,
   input  logic             rd_write_w,
   output logic [SEL_W-1:0] sel_c
);

   // x0 is never forwarded since it always reads as zero.
   always_comb begin
      sel_c = FWD_RF;
      if (rd_write_m && (rd_m != '0) && (rd_m == rs)) begin
         sel_c = FWD_MEM;
      end else if (rd_write_w && (rd_w != '0) && (rd_w == rs)) begin
         sel_c = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage RV32 core: forwarding selects,
// load-use / redirect / memory-wait strobes and a memory watchdog.
// Optional HAZARD_PERF_EN builds the stall/flush performance counters.
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_W-1:0]  rs1_d,
   input  logic [REG_W-1:0]  rs2_d,
   input  logic [REG_W-1:0]  rs1_e,
   input  logic [REG_W-1:0]  rs2_e,
   input  logic [REG_W-1:0]  rd_e,
   input  logic              rd_write_e,
   input  logic [1:0]        rd_write_src_e,
   input  logic              redirect_e,
   input  logic [REG_W-1:0]  rd_m,
   input  logic              rd_write_m,
   input  logic [REG_W-1:0]  rd_w,
   input  logic              rd_write_w,
   input  logic              mem_req_m,
   input  logic              mem_ready_m,
   output logic              stall_f,
   output logic              stall_d,
   output logic              stall_e,
   output logic              stall_m,
   output logic              flush_d,
   output logic              flush_e,
   output logic [SEL_W-1:0]  forwarding_rs1_e,
   output logic [SEL_W-1:0]  forwarding_rs2_e,
   output logic              mem_fault,
   output logic [PERF_W-1:0] stall_cycles,
   output logic [PERF_W-1:0] flush_count
);

   state_e            state;
   logic [WDOG_W-1:0] wdog;
   logic [WDOG_W-1:0] wdog_inc;
   logic              load_use;
   logic              waiting;
   strobe_t           strb;

   fwd_sel u_fwd_rs1 (
      .rs         (rs1_e),
      .rd_m       (rd_m),
      .rd_write_m (rd_write_m),
      .rd_w       (rd_w),
      .rd_write_w (rd_write_w),
      .sel_c      (forwarding_rs1_e)
   );

   fwd_sel u_fwd_rs2 (
      .rs         (rs2_e),
      .rd_m       (rd_m),
      .rd_write_m (rd_write_m),
      .rd_w       (rd_w),
      .rd_write_w (rd_write_w),
      .sel_c      (forwarding_rs2_e)
   );

   // Load in execute whose result is needed by the instruction in decode.
   assign load_use = rd_write_e && (rd_write_src_e == WB_LOAD) && (rd_e != '0) &&
                     ((rd_e == rs1_d) || (rd_e == rs2_d));

   // Outstanding memory access that is not completing this cycle.
   assign waiting  = !mem_ready_m && ((state == ST_MEM_WAIT) || mem_req_m);

   // Saturating watchdog increment; the counter never wraps.
   assign wdog_inc = (wdog == '1) ? wdog : wdog + WDOG_W'(1);

   // Strobes are combinational from state and inputs; wait > redirect > load-use.
   always_comb begin
      strb = '0;
      if (state == ST_RUN || state == ST_MEM_WAIT) begin
         if (waiting) begin
            strb.stall_f = 1'b1;
            strb.stall_d = 1'b1;
            strb.stall_e = 1'b1;
            strb.stall_m = 1'b1;
         end else if (redirect_e) begin
            strb.flush_d = 1'b1;
            strb.flush_e = 1'b1;
         end else if (load_use) begin
            strb.stall_f = 1'b1;
            strb.stall_d = 1'b1;
            strb.flush_e = 1'b1;
         end
      end else begin
         strb.stall_f = 1'b1;
         strb.stall_d = 1'b1;
         strb.stall_e = 1'b1;
         strb.stall_m = 1'b1;
      end
   end

   assign stall_f = strb.stall_f;
   assign stall_d = strb.stall_d;
   assign stall_e = strb.stall_e;
   assign stall_m = strb.stall_m;
   assign flush_d = strb.flush_d;
   assign flush_e = strb.flush_e;

   // Control FSM with watchdog and sticky fault; FAULT exits only through reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_RUN;
         wdog      <= '0;
         mem_fault <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (mem_req_m && !mem_ready_m) begin
                  state <= ST_MEM_WAIT;
                  wdog  <= WDOG_W'(1);
               end
            end
            ST_MEM_WAIT: begin
               if (mem_ready_m) begin
                  state <= ST_RUN;
               end else if (32'(wdog) >= MEM_TIMEOUT) begin
                  state     <= ST_FAULT;
                  mem_fault <= 1'b1;
               end else begin
                  wdog <= wdog_inc;
               end
            end
            ST_FAULT: begin
               mem_fault <= 1'b1;
            end
            default: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_EN
   logic [PERF_W-1:0] stall_cnt;
   logic [PERF_W-1:0] flush_cnt;

   // Free-running performance counters, wrapping modulo 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (strb.stall_f) begin
            stall_cnt <= stall_cnt + PERF_W'(1);
         end
         if (strb.flush_e) begin
            flush_cnt <= flush_cnt + PERF_W'(1);
         end
      end
   end

   assign stall_cycles = stall_cnt;
   assign flush_count  = flush_cnt;
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule
